// File: rtl/sort_check_pkg.sv
// rtl/sort_check_pkg.sv - shared types and constants for the sort read-back checker
package sort_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FIN  = 2'd3
    } sc_state_t;

    localparam int WORD_BYTES   = 4;
    localparam int READ_LATENCY = 1;

endpackage

// File: rtl/sort_check_reader.sv
// rtl/sort_check_reader.sv - walks a memory word array and flags the first non-ascending element
module sort_check_reader
    import sort_check_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       count,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              sorted,
    output logic [31:0]       fail_index
);

    sc_state_t         state_q, state_n;
    logic [ADDR_W-1:0] base_q, base_n;
    logic [31:0]       count_q, count_n;
    logic [31:0]       i_q, i_n;
    logic [DATA_W-1:0] prev_q, prev_n;
    logic [DATA_W-1:0] cur_q, cur_n;
    logic              sorted_n;
    logic [31:0]       fail_n;
    logic [ADDR_W-1:0] addr_n;

    always_comb begin
        state_n  = state_q;
        base_n   = base_q;
        count_n  = count_q;
        i_n      = i_q;
        prev_n   = prev_q;
        cur_n    = cur_q;
        sorted_n = sorted;
        fail_n   = fail_index;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_n   = base_addr & ~ADDR_W'(WORD_BYTES - 1);
                    count_n  = count;
                    i_n      = '0;
                    prev_n   = '0;
                    cur_n    = '0;
                    fail_n   = '0;
                    sorted_n = (count < 32'd2);
                    state_n  = (count < 32'd2) ? FIN : REQ;
                end
            end
            REQ: begin
                // cur still holds element i-1 here, so it becomes the left neighbour
                prev_n  = cur_q;
                state_n = WAIT;
            end
            WAIT: begin
                cur_n = mem_rdata;
                if (i_q != 32'd0 && $signed(prev_q) >= $signed(mem_rdata)) begin
                    sorted_n = 1'b0;
                    fail_n   = i_q;
                    state_n  = FIN;
                end else if (i_q == count_q - 32'd1) begin
                    sorted_n = 1'b1;
                    fail_n   = '0;
                    state_n  = FIN;
                end else begin
                    i_n     = i_q + 32'd1;
                    state_n = REQ;
                end
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Address wraps naturally at ADDR_W bits.
    assign addr_n = base_n + ADDR_W'(i_n) * ADDR_W'(WORD_BYTES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            i_q        <= '0;
            prev_q     <= '0;
            cur_q      <= '0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sorted     <= 1'b0;
            fail_index <= '0;
        end else begin
            state_q    <= state_n;
            base_q     <= base_n;
            count_q    <= count_n;
            i_q        <= i_n;
            prev_q     <= prev_n;
            cur_q      <= cur_n;
            mem_rd     <= (state_n == REQ);
            mem_addr   <= (state_n == REQ) ? addr_n : '0;
            busy       <= (state_n == REQ) || (state_n == WAIT);
            done       <= (state_n == FIN);
            sorted     <= sorted_n;
            fail_index <= fail_n;
        end
    end

endmodule

// File: tb/tb_sort_check_reader.sv
// tb/tb_sort_check_reader.sv - directed self-checking bench for sort_check_reader
module tb_sort_check_reader;

    logic        clk_tb = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] count;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        sorted;
    logic [31:0] fail_index;

    logic [31:0] mem [64];
    logic [31:0] rd_q [$];
    int          checks = 0;
    int          failures = 0;
    int          done_cyc;
    logic        busy1;

    always #5 clk_tb = ~clk_tb;

    sort_check_reader #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk_tb),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .count      (count),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .sorted     (sorted),
        .fail_index (fail_index)
    );

    always @(posedge clk_tb) if (mem_rd) mem_rdata <= mem[mem_addr[7:2]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] val);
        logic [31:0] a;
        a = addr;
        mem[a[7:2]] = val;
    endtask

    task automatic run(input logic [31:0] b, input logic [31:0] c, input int inject);
        rd_q.delete();
        done_cyc = -1;
        @(negedge clk_tb);
        base_addr = b;
        count = c;
        start = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk_tb);
            start = 1'b0;
            if (n == 1) busy1 = busy;
            if (mem_rd) rd_q.push_back(mem_addr);
            if (done) begin
                done_cyc = n;
                break;
            end
            if (n == inject) begin
                start = 1'b1;
                base_addr = 32'h0;
                count = 32'd2;
            end
        end
        if (done_cyc < 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        logic [31:0] bub [12];
        logic [31:0] srt [12];
        bub = '{32'd55, 32'd88, 32'd0, 32'd22, 32'd77, 32'd11, 32'd99, 32'd33,
                32'd110, 32'd66, 32'd121, 32'd44};
        for (int j = 0; j < 12; j++) srt[j] = 32'(j * 11);
        for (int j = 0; j < 64; j++) mem[j] = '0;
        mem_rdata = '0;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        repeat (2) @(negedge clk_tb);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sorted", sorted, 0);
        check("rst_fail_index", fail_index, 0);
        rst = 1'b0;

        for (int j = 0; j < 12; j++) put(32'd512 + 32'(4 * j), bub[j]);
        run(32'd512, 32'd12, 0);
        check("bub_sorted", sorted, 0);
        check("bub_fail_index", fail_index, 2);
        check("bub_done_cyc", done_cyc, 7);
        check("bub_busy_c1", busy1, 1);
        check("bub_busy_fin", busy, 0);
        check("bub_nreads", rd_q.size(), 3);
        if (rd_q.size() == 3) begin
            check("bub_addr0", rd_q[0], 512);
            check("bub_addr1", rd_q[1], 516);
            check("bub_addr2", rd_q[2], 520);
        end
        @(negedge clk_tb);
        check("done_one_cycle", done, 0);
        check("result_held", fail_index, 2);

        for (int j = 0; j < 12; j++) put(32'd512 + 32'(4 * j), srt[j]);
        run(32'd512, 32'd12, 0);
        check("srt_sorted", sorted, 1);
        check("srt_fail_index", fail_index, 0);
        check("srt_done_cyc", done_cyc, 25);
        check("srt_nreads", rd_q.size(), 12);
        if (rd_q.size() == 12)
            for (int j = 0; j < 12; j++) check("srt_addr", rd_q[j], 512 + 4 * j);

        put(32'd512, 32'hFFFF_FFFB); put(32'd516, 32'hFFFF_FFFF);
        put(32'd520, 32'd0);         put(32'd524, 32'd3);
        run(32'd512, 32'd4, 0);
        check("neg_sorted", sorted, 1);
        check("neg_done_cyc", done_cyc, 9);

        put(32'd512, 32'd1); put(32'd516, 32'd2); put(32'd520, 32'd2); put(32'd524, 32'd3);
        run(32'd512, 32'd4, 0);
        check("dup_sorted", sorted, 0);
        check("dup_fail_index", fail_index, 2);
        check("dup_done_cyc", done_cyc, 7);

        put(32'd512, 32'h7FFF_FFFF); put(32'd516, 32'h8000_0000);
        run(32'd512, 32'd2, 0);
        check("ovf_sorted", sorted, 0);
        check("ovf_fail_index", fail_index, 1);
        check("ovf_done_cyc", done_cyc, 5);

        run(32'd512, 32'd0, 0);
        check("c0_sorted", sorted, 1);
        check("c0_fail_index", fail_index, 0);
        check("c0_done_cyc", done_cyc, 1);
        check("c0_nreads", rd_q.size(), 0);
        check("c0_busy", busy1, 0);
        run(32'd512, 32'd1, 0);
        check("c1_sorted", sorted, 1);
        check("c1_done_cyc", done_cyc, 1);
        check("c1_nreads", rd_q.size(), 0);

        for (int j = 0; j < 12; j++) put(32'd512 + 32'(4 * j), srt[j]);
        run(32'd512, 32'd12, 4);
        check("inj_sorted", sorted, 1);
        check("inj_done_cyc", done_cyc, 25);
        check("inj_nreads", rd_q.size(), 12);

        @(negedge clk_tb);
        base_addr = 32'd512;
        count = 32'd12;
        start = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk_tb);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_mem_rd", mem_rd, 0);
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_sorted", sorted, 0);
        check("mid_rst_fail_index", fail_index, 0);
        @(negedge clk_tb);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk_tb);
            check("post_rst_idle", {done, mem_rd, busy}, 3'b000);
        end
        run(32'd512, 32'd12, 0);
        check("post_rst_sorted", sorted, 1);
        check("post_rst_done_cyc", done_cyc, 25);

        put(32'hFFFF_FFF8, 32'd1); put(32'hFFFF_FFFC, 32'd2); put(32'h0, 32'd3);
        run(32'hFFFF_FFF8, 32'd3, 0);
        check("wrap_sorted", sorted, 1);
        check("wrap_done_cyc", done_cyc, 7);
        check("wrap_nreads", rd_q.size(), 3);
        if (rd_q.size() == 3) begin
            check("wrap_addr0", rd_q[0], 32'hFFFF_FFF8);
            check("wrap_addr1", rd_q[1], 32'hFFFF_FFFC);
            check("wrap_addr2", rd_q[2], 32'h0000_0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
